lifo_stack: RTL
===============

# lifo_stack

Parametrised LIFO stack: the general-purpose successor to the team's fixed 8-bit × 16 stack. Width and depth are set by parameters. The block adds an occupancy count, a registered output-valid strobe, same-cycle push+pop (swap top), and one-cycle overflow/underflow error pulses. It sits between a producer issuing Push/Data_In and a consumer sampling Data_Out on Out_Valid, e.g. expression-evaluation or return-address storage.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries (≥2)
- AF_LEVEL, DEPTH-2, Almost_Full asserts when Count ≥ AF_LEVEL (used only with LIFO_STACK_ALMOST_EN)
- AE_LEVEL, 2, Almost_Empty asserts when Count ≤ AE_LEVEL (used only with LIFO_STACK_ALMOST_EN)
- CW, derived, $clog2(DEPTH+1): Count width

- Clk  in  1  clock, all state updates on rising edge
- RstN  in  1  reset, asynchronous, active-low
- Data_In  in  WIDTH  word to push
- Push  in  1  push request, sampled on Clk rising edge
- Pop  in  1  pop request, sampled on Clk rising edge
- Data_Out  out  WIDTH  registered popped word; holds value until next successful pop
- Out_Valid  out  1  one-cycle pulse: Data_Out updated this cycle
- Count  out  CW  current occupancy, 0..DEPTH
- Full  out  1  Count == DEPTH
- Empty  out  1  Count == 0
- Overflow  out  1  one-cycle pulse: push rejected
- Underflow  out  1  one-cycle pulse: pop rejected
- Almost_Full  out  1  see Configuration
- Almost_Empty  out  1  see Configuration

## Operation
- Storage: DEPTH × WIDTH register array, not reset. Stack pointer = Count; top entry at index Count-1.
- Reset (RstN low, asynchronous): Count=0, Data_Out=0, Out_Valid=0, Empty=1, Full=0, Overflow=0, Underflow=0, Almost_Full=0, Almost_Empty=1 (0 when macro absent).
- Per-edge action, decided by {Push, Pop} and Count:
  - Push only, Count<DEPTH: mem[Count]←Data_In, Count+1.
  - Push only, Count==DEPTH: no write, Count unchanged, Overflow=1.
  - Pop only, Count>0: Data_Out←mem[Count-1], Out_Valid=1, Count-1.
  - Pop only, Count==0: Data_Out holds, Out_Valid=0, Underflow=1.
  - Push+Pop, Count>0 (including full): swap. Data_Out←mem[Count-1], mem[Count-1]←Data_In, Out_Valid=1, Count unchanged, no error.
  - Push+Pop, Count==0: bypass. Data_Out←Data_In, Out_Valid=1, Count stays 0, no error.
  - Neither: all state holds; pulse outputs return to 0.
- Full, Empty, and almost flags are decoded from the Count register. They are never combinational from Push/Pop.
- Count arithmetic is CW bits wide and never wraps. Out-of-range requests are rejected as described above.

## Timing
- All outputs are registered or decoded from registers. There is no combinational path from any input to any output.
- Pop latency: 1 cycle. Data_Out and Out_Valid are valid in the cycle after the edge that sampled Pop.
- Count, Full, and Empty reflect a push/pop in the cycle after the sampling edge.
- Back-to-back operations are allowed every cycle. A word pushed at edge N is poppable at edge N+1.
- Overflow, Underflow, and Out_Valid are high for exactly one cycle per rejected or accepted request.
- Reset mid-operation: all outputs go to reset values immediately, without waiting for Clk. Stored data is discarded logically (Count=0). The first edge after RstN rises is a normal operation edge.

## Configuration
- LIFO_STACK_ALMOST_EN defined: Almost_Full = (Count ≥ AF_LEVEL) and Almost_Empty = (Count ≤ AE_LEVEL), both registered-decoded alongside Full/Empty.
- LIFO_STACK_ALMOST_EN undefined: comparator logic is not compiled. Almost_Full and Almost_Empty are tied to 0, and AF_LEVEL/AE_LEVEL are ignored.

## Test plan
(All with WIDTH=8, DEPTH=16.)
- Reset check: assert RstN low mid-push sequence → Count=0, Empty=1, Full=0, Data_Out=0, Out_Valid=0, asynchronously within the same cycle.
- Push/pop order: push 0x11,0x22,0x33, then pop ×3 → Data_Out 0x33,0x22,0x11 with one Out_Valid pulse each, Count 3→0, Empty=1 at the end.
- Fill and overflow: push 0x00..0x0F, then push 0xAA → Full=1, Count=16, Overflow pulses once, next pop returns 0x0F (not 0xAA).
- Empty underflow: pop with Count=0 → Underflow pulses once, Out_Valid=0, Data_Out keeps its previous value, Count stays 0.
- Swap and bypass: stack holding 0x05, Push+Pop with Data_In=0x77 → Data_Out=0x05 and Count=1; then pop → 0x77. With Count=0, Push+Pop with 0x3C → Data_Out=0x3C, Out_Valid=1, Count=0, no error pulse.
- Almost flags (macro defined, AF_LEVEL=14, AE_LEVEL=2): push 14 words → Almost_Full rises on the 14th. Pop down to 2 → Almost_Empty=1. With the macro undefined, both flags stay 0 throughout.

Source files
------------

// File: rtl/lifo_stack.sv
// lifo_stack: parametrised LIFO stack with occupancy count, registered pop
// output with valid strobe, same-cycle push+pop (swap top / bypass when
// empty) and one-cycle overflow/underflow pulses.
// Optional feature macro: LIFO_STACK_ALMOST_EN enables the Almost_Full /
// Almost_Empty comparators; without it both flags are tied low.
module lifo_stack #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic [WIDTH-1:0] Data_In,
  input  logic             Push,
  input  logic             Pop,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Out_Valid,
  output logic [CW-1:0]    Count,
  output logic             Full,
  output logic             Empty,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Almost_Full,
  output logic             Almost_Empty
);

  localparam int AW = $clog2(DEPTH);

  // Storage is deliberately not reset; Count alone defines what is valid.
  logic [WIDTH-1:0] mem_reg [DEPTH];

  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] data_out_reg, data_out_next;
  logic             out_valid_reg, out_valid_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;

  logic             full_w, empty_w;
  logic [CW-1:0]    top_full;
  logic [AW-1:0]    top_idx;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;

  // Status flags come from the count register only, never from Push/Pop.
  assign full_w   = (count_reg == CW'(DEPTH));
  assign empty_w  = (count_reg == '0);
  assign top_full = count_reg - CW'(1);
  assign top_idx  = AW'(top_full);

  // Decode the per-edge action from {Push, Pop} and the current occupancy.
  always_comb begin
    count_next     = count_reg;
    data_out_next  = data_out_reg;
    out_valid_next = 1'b0;
    overflow_next  = 1'b0;
    underflow_next = 1'b0;
    wr_en          = 1'b0;
    wr_idx         = AW'(count_reg);
    unique case ({Push, Pop})
      2'b10: begin
        if (full_w) begin
          overflow_next = 1'b1;
        end else begin
          wr_en      = 1'b1;
          wr_idx     = AW'(count_reg);
          count_next = count_reg + CW'(1);
        end
      end
      2'b01: begin
        if (empty_w) begin
          underflow_next = 1'b1;
        end else begin
          data_out_next  = mem_reg[top_idx];
          out_valid_next = 1'b1;
          count_next     = top_full;
        end
      end
      2'b11: begin
        out_valid_next = 1'b1;
        if (empty_w) begin
          // Nothing stored: the incoming word passes straight to the output.
          data_out_next = Data_In;
        end else begin
          // Swap: old top leaves, incoming word takes its slot.
          data_out_next = mem_reg[top_idx];
          wr_en         = 1'b1;
          wr_idx        = top_idx;
        end
      end
      default: ;
    endcase
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      count_reg     <= '0;
      data_out_reg  <= '0;
      out_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      count_reg     <= count_next;
      data_out_reg  <= data_out_next;
      out_valid_reg <= out_valid_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Storage write port (push into free slot, or overwrite top on swap).
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem_reg[wr_idx] <= Data_In;
    end
  end

  assign Data_Out  = data_out_reg;
  assign Out_Valid = out_valid_reg;
  assign Count     = count_reg;
  assign Full      = full_w;
  assign Empty     = empty_w;
  assign Overflow  = overflow_reg;
  assign Underflow = underflow_reg;

`ifdef LIFO_STACK_ALMOST_EN
  assign Almost_Full  = (count_reg >= CW'(AF_LEVEL));
  assign Almost_Empty = (count_reg <= CW'(AE_LEVEL));
`else
  assign Almost_Full  = 1'b0;
  assign Almost_Empty = 1'b0;
`endif

endmodule
